mux_4: RTL and testbench



---
 rtl/mux4_pkg.sv | 13 +
 rtl/mux_4_pc_reg.sv | 40 ++++
 rtl/mux_4.sv | 80 ++++++++
 tb/tb_mux_4.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared definitions for the fetch-stage next-PC selector: width/reset
// defaults and the select encoding.
package mux4_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    PC_SEL_PLUS4 = 1'b0,
    PC_SEL_ALU   = 1'b1
  } pc_sel_e;

endpackage

// File: rtl/mux_4_pc_reg.sv
// Architectural PC register: load-enabled, synchronous active-high reset
// to a configurable vector.
module pc_reg
  import mux4_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Next-state: load on enable, otherwise hold (stall).
  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = d;
    end else begin
      pc_d = pc_q;
    end
  end

  // State register; reset wins over any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign q = pc_q;

endmodule

// File: rtl/mux_4.sv
// Next-PC selector for the RV32I fetch stage with registered PC and redirect
// counter. Optional target-misalignment flag via MUX4_MISALIGN_CHECK_EN.
module mux_4
  import mux4_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] pc_four,
  input  logic            pc_sel,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_q,
  output logic            redirect,
  output logic            misaligned,
  output logic [31:0]     redirect_cnt
);

  pc_sel_e         sel_s;
  logic [XLEN-1:0] pc_next_s;
  logic [31:0]     redirect_cnt_d;
  logic [31:0]     redirect_cnt_q;

  assign sel_s = pc_sel_e'(pc_sel);

  // Pure select; an unknown select yields an unknown PC rather than a guess.
  always_comb begin
    pc_next_s = {XLEN{1'bx}};
    case (sel_s)
      PC_SEL_PLUS4: pc_next_s = pc_four;
      PC_SEL_ALU:   pc_next_s = alu_data;
      default:      pc_next_s = {XLEN{1'bx}};
    endcase
  end

  assign pc_next  = pc_next_s;
  assign redirect = pc_sel;

`ifdef MUX4_MISALIGN_CHECK_EN
  assign misaligned = pc_sel & (alu_data[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Count redirects that are actually taken into the PC (wraps naturally).
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    if (en && pc_sel) begin
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= 32'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;

  pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (pc_next_s),
    .q   (pc_q)
  );

endmodule

// File: tb/tb_mux_4.sv
// Scoreboard bench for mux_4: driver pushes expected outputs computed from a
// behavioural PC/counter model; a negedge monitor pops and compares.
module tb_mux_4;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] alu_data = 32'd0;
  logic [31:0] pc_four  = 32'd0;
  logic        pc_sel   = 1'b0;
  logic [31:0] pc_next;
  logic [31:0] pc_q;
  logic        redirect;
  logic        misaligned;
  logic [31:0] redirect_cnt;

  mux_4 dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .alu_data     (alu_data),
    .pc_four      (pc_four),
    .pc_sel       (pc_sel),
    .pc_next      (pc_next),
    .pc_q         (pc_q),
    .redirect     (redirect),
    .misaligned   (misaligned),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_next;
    logic        redirect;
    logic        misaligned;
    logic        chk_reg;
    logic [31:0] pc_q;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Model state: architectural PC and redirect count, valid after first reset.
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_cnt   = 32'd0;
  logic        m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, record expectations.
  task automatic cycle(input logic r, input logic e, input logic [1:0] sel_raw,
                       input logic [31:0] alu, input logic [31:0] four);
    exp_t x;
    logic s;
    @(posedge clk);
    #1;
    s        = sel_raw[0];
    rst      = r;
    en       = e;
    pc_sel   = s;
    alu_data = alu;
    pc_four  = four;
    if (s) x.pc_next = alu; else x.pc_next = four;
    x.redirect = s;
`ifdef MUX4_MISALIGN_CHECK_EN
    x.misaligned = s && (alu % 32'd4 != 32'd0);
`else
    x.misaligned = 1'b0;
`endif
    x.chk_reg = m_valid;
    x.pc_q    = m_pc;
    x.cnt     = m_cnt;
    exp_q.push_back(x);
    if (r) begin
      m_pc = RV; m_cnt = 32'd0; m_valid = 1'b1;
    end else if (e) begin
      m_pc = x.pc_next;
      if (s) m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("pc_next", pc_next, x.pc_next);
        chk("redirect", {31'd0, redirect}, {31'd0, x.redirect});
        chk("misaligned", {31'd0, misaligned}, {31'd0, x.misaligned});
        if (x.chk_reg) begin
          chk("pc_q", pc_q, x.pc_q);
          chk("redirect_cnt", redirect_cnt, x.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    // Pure mux behaviour before any reset.
    cycle(1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0000_0004);
    cycle(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0004);
    cycle(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0000_0004);
    // Reset then sequential load.
    cycle(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0004);
    cycle(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0004);
    // Stall with redirect pending, then accept.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd1, 32'h0000_0100, 32'h0000_0008);
    cycle(1'b0, 1'b1, 2'd1, 32'h0000_0100, 32'h0000_0008);
    cycle(1'b0, 1'b0, 2'd0, 32'h0000_0102, 32'h0000_0104);
    // Reset overrides a pending redirect.
    cycle(1'b1, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_0104);
    cycle(1'b0, 1'b0, 2'd1, 32'h0000_0203, 32'h0000_0004);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), a, $urandom);
    end
    cycle(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end else begin
      n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
